transmissor_periferico: RTL and testbench
=========================================

# transmissor_periferico

Peripheral-side transmitter for the 4-bit `send`/`ack` four-phase handshake. It carries data in the reverse direction, from peripheral to CPU, where the existing path carries data from CPU to peripheral. Words arrive from local peripheral logic over a valid/ready port and are buffered in a small FIFO. Each word is then driven onto `dados` with `send` asserted, and the block waits for the remote receiver's `ack` to rise and then fall. `ack` comes from another clock domain and is synchronized internally.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries, power of two, 2..16.
- `W`, 4: data width; matches the `dados` bus.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `dadosIn` input W: word to transmit.
- `validIn` input 1: `dadosIn` is valid this cycle.
- `readyIn` output 1: FIFO can accept a word. Equals `count != DEPTH`.
- `dados` output W: word on the handshake bus. Registered and held stable while `send`=1.
- `send` output 1: request to the remote receiver. Registered.
- `ack` input 1: acknowledge from the remote receiver. Asynchronous to `clk`.
- `estadoTx` output 2: current FSM state. 0=OCIOSO, 1=ENVIA, 2=ESPERA; 3 is unused.
- `count` output $clog2(DEPTH)+1: FIFO occupancy.
- `enviados` output 8: count of completed transfers. Wraps 255→0.

## Operation
- **Accept:** a push happens when `validIn && readyIn` at a rising edge. The word is written at the tail.
- **ACK sync:** `ack` passes through a 2-flop synchronizer, giving `ack_s`. The FSM uses only `ack_s`.
- **OCIOSO:** if `count>0` at a rising edge:
  - load `dados` ← head word;
  - set `send`←1;
  - pop the head;
  - go to ENVIA.
  - Otherwise stay in OCIOSO. `send`=0.
- **ENVIA:** hold `dados` and `send`=1. When `ack_s`=1, set `send`←0 and go to ESPERA.
- **ESPERA:** `send`=0. When `ack_s`=0:
  - increment `enviados`;
  - go to OCIOSO.
  - `dados` keeps the last word until the next load.
- **Push and pop in the same edge:** `count` is unchanged and both pointers advance.
- **Full FIFO:** `readyIn`=0 and `validIn` is ignored; no overflow is possible. A pop on an edge raises `readyIn` on the next cycle. `readyIn` is not combinationally dependent on the pop.
- **Empty FIFO in OCIOSO:** stays idle indefinitely.
- **Illegal state 3:** next state is OCIOSO with `send`←0.
- **Reset, including mid-transfer:**
  - `send`=0, `dados`=0, `estadoTx`=0, `count`=0, `readyIn`=1, `enviados`=0;
  - synchronizer flops cleared;
  - FIFO contents discarded.
  - The remote receiver must tolerate `send` dropping without a completed handshake.

## Timing
- **Push to send:** a push at edge N into an empty FIFO in OCIOSO makes `send`=1 and `dados` valid after edge N+1.
- **ACK latency:** `ack` rising before edge M is seen as `ack_s`=1 after edge M+1. `send` falls after edge M+2.
- **Release latency:** `ack` falling before edge K gives return to OCIOSO and an `enviados` increment after edge K+2.
- **Back-to-back transfers:** the next word loads on the first edge in OCIOSO. The minimum gap between `send` pulses is one cycle low in OCIOSO plus the ESPERA cycles.
- **Four-phase rules:**
  - `send` never rises while `ack_s`=1;
  - `dados` changes only on the edge that raises `send`.

## Structure
- Shared package `handshake_pkg` holds:
  - the state enum/constants `OCIOSO`, `ENVIA`, `ESPERA` (2-bit);
  - the default data width 4.
  - The CPU and peripheral modules import the same package.
- One sub-module: `sync2`, a 2-flop synchronizer with async active-high reset, reused wherever `send`/`ack` cross domains.
- The FIFO is inline: array plus read/write pointers and `count`.

## Test plan
- **Reset:** assert `rst` for 3 cycles, then release → `send`=0, `dados`=0, `estadoTx`=0, `count`=0, `readyIn`=1, `enviados`=0. Assert `rst` asynchronously mid-ENVIA → `send` drops with no clock edge.
- **Single transfer:** push `4'hA` with a responsive model receiver that raises `ack` 2 cycles after seeing `send` and drops it 2 cycles after `send` falls → `dados`=`4'hA` stable for the whole `send` pulse, one handshake, `enviados`=1, `count` returns to 0.
- **Burst/full:** push `1,2,3,4,5` back-to-back with a stalled receiver (`ack`=0) → `4'h1` loads into `dados` (`count`=0) and `2,3,4,5` fill the FIFO (`count`=4). `readyIn` then drops and the 6th word is refused. After release, `dados` sequence is `1,2,3,4,5` and `enviados`=5.
- **Simultaneous push/pop:** with `count`=2, push on the same edge OCIOSO pops → `count` stays 2 and order is preserved.
- **Asynchronous ack:** drive `ack` from a 20 ns clock while `clk` is 10 ns (receiver model matching the existing peripheral) → no lost or duplicated words over 50 random words. Data is checked against a scoreboard.
- **Wrap-around:** 260 transfers → `enviados`=4, FIFO pointers wrap with no corruption.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared definitions for the send/ack four-phase handshake (CPU and peripheral sides).
package handshake_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ENVIA  = 2'd1,
    ESPERA = 2'd2
  } estado_t;

  localparam int DATA_W = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single control bit crossing into the local clock domain.
module sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/transmissor_periferico.sv
// Peripheral-to-CPU transmitter: valid/ready input FIFO feeding the send/ack four-phase handshake.
module transmissor_periferico
  import handshake_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [W-1:0]               dadosIn,
  input  logic                       validIn,
  output logic                       readyIn,
  output logic [W-1:0]               dados,
  output logic                       send,
  input  logic                       ack,
  output logic [1:0]                 estadoTx,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 enviados
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  estado_t        r_state;
  estado_t        w_state_nxt;
  logic [W-1:0]   r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [W-1:0]   r_dados;
  logic           r_send;
  logic [7:0]     r_enviados;
  logic           w_ack_s;
  logic           w_push;
  logic           w_pop;
  logic           w_send_nxt;
  logic           w_inc;

  sync2 u_sync_ack (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (ack),
    .o_q   (w_ack_s)
  );

  // readyIn comes from the registered count only, so a pop frees space one cycle later
  assign readyIn = (r_count != CW'(DEPTH));
  assign w_push  = validIn && readyIn;

  // The !ack_s guard keeps send from rising into a still-high ack after a mid-transfer reset
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_send_nxt  = r_send;
    w_inc       = 1'b0;
    case (r_state)
      OCIOSO: begin
        w_send_nxt = 1'b0;
        if ((r_count != '0) && !w_ack_s) begin
          w_pop       = 1'b1;
          w_send_nxt  = 1'b1;
          w_state_nxt = ENVIA;
        end
      end
      ENVIA: begin
        w_send_nxt = 1'b1;
        if (w_ack_s) begin
          w_send_nxt  = 1'b0;
          w_state_nxt = ESPERA;
        end
      end
      ESPERA: begin
        w_send_nxt = 1'b0;
        if (!w_ack_s) begin
          w_inc       = 1'b1;
          w_state_nxt = OCIOSO;
        end
      end
      default: begin
        w_send_nxt  = 1'b0;
        w_state_nxt = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= OCIOSO;
      r_send     <= 1'b0;
      r_dados    <= '0;
      r_enviados <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_send  <= w_send_nxt;
      if (w_pop) begin
        r_dados <= r_mem[r_rd_ptr];
      end
      if (w_inc) begin
        r_enviados <= r_enviados + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= dadosIn;
    end
  end

  assign dados    = r_dados;
  assign send     = r_send;
  assign estadoTx = r_state;
  assign count    = r_count;
  assign enviados = r_enviados;

endmodule

// File: tb/tb_transmissor_periferico.sv
// Scoreboard bench for transmissor_periferico with a model four-phase receiver.
module tb_transmissor_periferico;

  logic       clk = 1'b0;
  logic       clk_rx = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dadosIn = 4'h0;
  logic       validIn = 1'b0;
  logic       readyIn;
  logic [3:0] dados;
  logic       send;
  logic       ack = 1'b0;
  logic [1:0] estadoTx;
  logic [2:0] count;
  logic [7:0] enviados;

  int checks = 0;
  int failures = 0;
  int sent_seen = 0;
  logic [3:0] exp_q [$];

  transmissor_periferico #(.DEPTH(4), .W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .dadosIn  (dadosIn),
    .validIn  (validIn),
    .readyIn  (readyIn),
    .dados    (dados),
    .send     (send),
    .ack      (ack),
    .estadoTx (estadoTx),
    .count    (count),
    .enviados (enviados)
  );

  always #5 clk = ~clk;
  initial begin
    #3;
    forever #10 clk_rx = ~clk_rx;
  end

  // Receiver model: 0 = stalled, 1 = ticks on clk negedge, 2 = ticks on independent 20 ns clock
  logic [1:0] rx_mode = 2'd0;
  int rx_st = 0;
  int rx_cnt = 0;
  wire rx_tick = (rx_mode == 2'd2) ? clk_rx : ~clk;

  always @(posedge rx_tick or posedge rst) begin
    if (rst || rx_mode == 2'd0) begin
      ack = 1'b0;
      rx_st = 0;
    end else begin
      case (rx_st)
        0: if (send) begin rx_cnt = 2; rx_st = 1; end
        1: begin rx_cnt--; if (rx_cnt == 0) begin ack = 1'b1; rx_st = 2; end end
        2: if (!send) begin rx_cnt = 2; rx_st = 3; end
        default: begin rx_cnt--; if (rx_cnt == 0) begin ack = 1'b0; rx_st = 0; end end
      endcase
    end
  end

  // Monitor: every send rise is a delivered word, checked against the scoreboard
  logic       prev_send = 1'b0;
  logic [3:0] held = 4'h0;
  logic [3:0] exp_w;
  always @(negedge clk) begin
    if (rst) begin
      prev_send = 1'b0;
    end else begin
      if (send && !prev_send) begin
        sent_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL word_order: got dados=%h, expected no word (scoreboard empty)", dados);
        end else begin
          exp_w = exp_q.pop_front();
          if (dados !== exp_w) begin
            failures++;
            $display("FAIL word_order: got dados=%h, expected %h", dados, exp_w);
          end
        end
        held = dados;
      end else if (send && prev_send) begin
        checks++;
        if (dados !== held) begin
          failures++;
          $display("FAIL dados_stable: got %h during send, expected %h", dados, held);
        end
      end
      prev_send = send;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] d);
    int n;
    @(negedge clk);
    dadosIn = d;
    validIn = 1'b1;
    n = 0;
    while (!readyIn && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!readyIn) chk("push_ready_timeout", {31'd0, readyIn}, 32'd1);
    else begin
      @(posedge clk);
      exp_q.push_back(d);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    validIn = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && count == 3'd0 && estadoTx == 2'd0 && !send && rx_st == 0)
           && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'd0, (k < budget)}, 32'd1);
  endtask

  initial begin
    int k;
    int base_seen;

    // Reset held for 3 cycles
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_send", {31'd0, send}, 32'd0);
    chk("rst_dados", {28'd0, dados}, 32'd0);
    chk("rst_estado", {30'd0, estadoTx}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_readyIn", {31'd0, readyIn}, 32'd1);
    chk("rst_enviados", {24'd0, enviados}, 32'd0);

    // Single transfer
    rx_mode = 2'd1;
    push(4'hA);
    idle();
    wait_drain("single_drain", 200);
    chk("single_enviados", {24'd0, enviados}, 32'd1);
    chk("single_count", {29'd0, count}, 32'd0);
    chk("single_dados_hold", {28'd0, dados}, 32'hA);
    chk("single_seen", sent_seen, 32'd1);

    // Asynchronous reset in the middle of ENVIA
    rx_mode = 2'd0;
    push(4'hB);
    idle();
    k = 0;
    while (estadoTx != 2'd1 && k < 50) begin @(negedge clk); k++; end
    chk("midrst_reach_envia", {30'd0, estadoTx}, 32'd1);
    chk("midrst_send_before", {31'd0, send}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_send", {31'd0, send}, 32'd0);
    chk("midrst_estado", {30'd0, estadoTx}, 32'd0);
    chk("midrst_dados", {28'd0, dados}, 32'd0);
    chk("midrst_enviados", {24'd0, enviados}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Burst into a stalled receiver until full
    push(4'h1);
    push(4'h2);
    push(4'h3);
    push(4'h4);
    push(4'h5);
    @(negedge clk);
    chk("burst_count_full", {29'd0, count}, 32'd4);
    chk("burst_readyIn_low", {31'd0, readyIn}, 32'd0);
    chk("burst_dados_first", {28'd0, dados}, 32'h1);
    chk("burst_estado_envia", {30'd0, estadoTx}, 32'd1);
    dadosIn = 4'h6;
    repeat (3) @(negedge clk);
    chk("burst_refused_count", {29'd0, count}, 32'd4);
    validIn = 1'b0;
    rx_mode = 2'd1;
    wait_drain("burst_drain", 500);
    chk("burst_enviados", {24'd0, enviados}, 32'd5);

    // Push on the same edge that OCIOSO pops
    rx_mode = 2'd0;
    push(4'h7);
    push(4'h8);
    push(4'h9);
    idle();
    chk("simul_pre_count", {29'd0, count}, 32'd2);
    rx_mode = 2'd1;
    k = 0;
    while (estadoTx != 2'd0 && k < 200) begin @(negedge clk); k++; end
    chk("simul_reach_ocioso", {30'd0, estadoTx}, 32'd0);
    chk("simul_count_before", {29'd0, count}, 32'd2);
    dadosIn = 4'hC;
    validIn = 1'b1;
    @(posedge clk);
    exp_q.push_back(4'hC);
    @(negedge clk);
    validIn = 1'b0;
    chk("simul_count_after", {29'd0, count}, 32'd2);
    chk("simul_estado", {30'd0, estadoTx}, 32'd1);
    wait_drain("simul_drain", 500);
    chk("simul_enviados", {24'd0, enviados}, 32'd9);

    // Receiver on an independent clock, 50 random words
    rx_mode = 2'd2;
    base_seen = sent_seen;
    for (int i = 0; i < 50; i++) begin
      push(4'($urandom_range(0, 15)));
    end
    idle();
    wait_drain("async_drain", 5000);
    chk("async_enviados", {24'd0, enviados}, 32'd59);
    chk("async_seen", sent_seen - base_seen, 32'd50);

    // 260 transfers: enviados wraps, FIFO pointers wrap many times
    rst = 1'b1;
    rx_mode = 2'd1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base_seen = sent_seen;
    for (int i = 0; i < 260; i++) begin
      push(4'(i));
    end
    idle();
    wait_drain("wrap_drain", 20000);
    chk("wrap_enviados", {24'd0, enviados}, 32'd4);
    chk("wrap_seen", sent_seen - base_seen, 32'd260);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
